// File: rtl/note_score_tally.sv
// note_score_tally: scoring stage behind the falling-arrow note droppers.
// Tallies each note once, on the first rising edge of its hit or miss flag.
// Keeps score, combo, best combo, and hit/miss totals, and reports when the
// song is finished.
// Optional feature macro: SCORE_COMBO_BONUS_EN. When it is defined, a hit
// scores 2 points while the pre-frame combo is 10 or more.
module note_score_tally #(
  parameter int N_NOTES   = 32,
  parameter int SCORE_MAX = 9999
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic [7:0]         keycode,
  input  logic [N_NOTES-1:0] hit_vec,
  input  logic [N_NOTES-1:0] miss_vec,
  output logic [13:0]        score,
  output logic [7:0]         combo,
  output logic [7:0]         max_combo,
  output logic [6:0]         hit_count,
  output logic [6:0]         miss_count,
  output logic               playing,
  output logic               game_over
);

  localparam int         CNT_W     = $clog2(N_NOTES + 1);
  localparam logic [7:0] KEY_START = 8'h2c;
  localparam logic [7:0] KEY_IDLE  = 8'h01;

  typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_DONE} state_t;

  state_t             state_p0, state_nxt;
  logic [N_NOTES-1:0] prev_hit_p0, prev_miss_p0;
  logic [N_NOTES-1:0] resolved_p0, resolved_nxt;
  logic [N_NOTES-1:0] hit_rise, miss_rise;
  logic [CNT_W-1:0]   h, m;
  logic [1:0]         pts;
  logic [7:0]         c1;
  logic [14:0]        score_sum;
  logic [13:0]        score_nxt;
  logic [7:0]         combo_nxt, max_combo_nxt;
  logic [6:0]         hit_count_nxt, miss_count_nxt;

  function automatic logic [CNT_W-1:0] popcount(input logic [N_NOTES-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_NOTES; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  function automatic logic [7:0] sat255(input logic [8:0] v);
    return (v > 9'd255) ? 8'd255 : v[7:0];
  endfunction

  function automatic logic [13:0] clamp_score(input logic [14:0] v);
    return (v > 15'(SCORE_MAX)) ? 14'(SCORE_MAX) : v[13:0];
  endfunction

  // Edge detection against the previous frame, masked by notes already tallied
  assign hit_rise  = hit_vec & ~prev_hit_p0 & ~resolved_p0;
  assign miss_rise = miss_vec & ~prev_miss_p0 & ~resolved_p0 & ~hit_rise;
  assign h         = popcount(hit_rise);
  assign m         = popcount(miss_rise);

`ifdef SCORE_COMBO_BONUS_EN
  assign pts = (combo >= 8'd10) ? 2'd2 : 2'd1;
`else
  assign pts = 2'd1;
`endif

  assign score_sum = 15'(score) + 15'(h) * 15'(pts);
  assign c1        = sat255(9'(combo) + 9'(h));

  // Next-state and tally update for the current frame
  always_comb begin
    state_nxt      = state_p0;
    resolved_nxt   = resolved_p0;
    score_nxt      = score;
    combo_nxt      = combo;
    max_combo_nxt  = max_combo;
    hit_count_nxt  = hit_count;
    miss_count_nxt = miss_count;
    case (state_p0)
      ST_IDLE: begin
        if (keycode == KEY_START) begin
          state_nxt      = ST_PLAY;
          resolved_nxt   = '0;
          score_nxt      = '0;
          combo_nxt      = '0;
          max_combo_nxt  = '0;
          hit_count_nxt  = '0;
          miss_count_nxt = '0;
        end
      end
      ST_PLAY: begin
        resolved_nxt   = resolved_p0 | hit_rise | miss_rise;
        hit_count_nxt  = hit_count + 7'(h);
        miss_count_nxt = miss_count + 7'(m);
        score_nxt      = clamp_score(score_sum);
        max_combo_nxt  = (c1 > max_combo) ? c1 : max_combo;
        combo_nxt      = (m != '0) ? 8'd0 : c1;
        if (&resolved_p0) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_DONE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    if (keycode == KEY_IDLE) begin
      state_nxt = ST_IDLE;
    end
  end

  // Frame register boundary: state, history, tallies and status flags
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_p0     <= ST_IDLE;
      prev_hit_p0  <= '0;
      prev_miss_p0 <= '0;
      resolved_p0  <= '0;
      score        <= '0;
      combo        <= '0;
      max_combo    <= '0;
      hit_count    <= '0;
      miss_count   <= '0;
      playing      <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      state_p0     <= state_nxt;
      prev_hit_p0  <= hit_vec;
      prev_miss_p0 <= miss_vec;
      resolved_p0  <= resolved_nxt;
      score        <= score_nxt;
      combo        <= combo_nxt;
      max_combo    <= max_combo_nxt;
      hit_count    <= hit_count_nxt;
      miss_count   <= miss_count_nxt;
      playing      <= (state_nxt == ST_PLAY);
      game_over    <= (state_nxt == ST_DONE);
    end
  end

endmodule

// File: tb/tb_note_score_tally.sv
// Bench for note_score_tally: directed frames, a per-note behavioural model,
// and per-frame comparison of every output, plus hand-computed checkpoints.
module tb_note_score_tally;

  localparam int N  = 32;
  localparam int SM = 30;

  logic          frame_clk = 1'b0;
  logic          Reset;
  logic [7:0]    keycode;
  logic [N-1:0]  hit_vec, miss_vec;
  logic [13:0]   score;
  logic [7:0]    combo, max_combo;
  logic [6:0]    hit_count, miss_count;
  logic          playing, game_over;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model state
  int m_mode;
  int m_score, m_combo, m_max, m_hits, m_miss;
  bit m_res [N];
  bit m_ph  [N];
  bit m_pm  [N];

  note_score_tally #(.N_NOTES(N), .SCORE_MAX(SM)) dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .keycode    (keycode),
    .hit_vec    (hit_vec),
    .miss_vec   (miss_vec),
    .score      (score),
    .combo      (combo),
    .max_combo  (max_combo),
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .playing    (playing),
    .game_over  (game_over)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: walks the notes one by one each frame
  always @(posedge frame_clk) begin : model
    int  nh, nm, pts, c1;
    bit  all_res, hr, mr;
    if (Reset) begin
      m_mode = 0; m_score = 0; m_combo = 0; m_max = 0; m_hits = 0; m_miss = 0;
      for (int i = 0; i < N; i++) begin
        m_res[i] = 0; m_ph[i] = 0; m_pm[i] = 0;
      end
    end else begin
      all_res = 1;
      for (int i = 0; i < N; i++) if (!m_res[i]) all_res = 0;
`ifdef SCORE_COMBO_BONUS_EN
      pts = (m_combo >= 10) ? 2 : 1;
`else
      pts = 1;
`endif
      nh = 0; nm = 0;
      if (m_mode == 1) begin
        for (int i = 0; i < N; i++) begin
          hr = hit_vec[i] && !m_ph[i] && !m_res[i];
          mr = miss_vec[i] && !m_pm[i] && !m_res[i] && !hr;
          if (hr) begin nh++; m_res[i] = 1; end
          if (mr) begin nm++; m_res[i] = 1; end
        end
        m_hits  += nh;
        m_miss  += nm;
        m_score  = m_score + nh * pts;
        if (m_score > SM) m_score = SM;
        c1 = m_combo + nh;
        if (c1 > 255) c1 = 255;
        if (c1 > m_max) m_max = c1;
        m_combo = (nm != 0) ? 0 : c1;
      end
      if (keycode == 8'h01) begin
        m_mode = 0;
      end else if (m_mode == 0 && keycode == 8'h2c) begin
        m_mode = 1; m_score = 0; m_combo = 0; m_max = 0; m_hits = 0; m_miss = 0;
        for (int i = 0; i < N; i++) m_res[i] = 0;
      end else if (m_mode == 1 && all_res) begin
        m_mode = 2;
      end
      for (int i = 0; i < N; i++) begin
        m_ph[i] = hit_vec[i];
        m_pm[i] = miss_vec[i];
      end
    end
  end

  // Per-frame comparison against the model, away from the active edge
  always @(negedge frame_clk) begin
    if (chk_en) begin
      check("score",      32'(score),      32'(m_score));
      check("combo",      32'(combo),      32'(m_combo));
      check("max_combo",  32'(max_combo),  32'(m_max));
      check("hit_count",  32'(hit_count),  32'(m_hits));
      check("miss_count", 32'(miss_count), 32'(m_miss));
      check("playing",    32'(playing),    32'(m_mode == 1));
      check("game_over",  32'(game_over),  32'(m_mode == 2));
    end
  end

  task automatic frame();
    @(posedge frame_clk);
    @(negedge frame_clk);
  endtask

  initial begin : stim
    int exp12;
`ifdef SCORE_COMBO_BONUS_EN
    exp12 = 14;
`else
    exp12 = 12;
`endif
    Reset = 1'b1; keycode = 8'h00; hit_vec = '0; miss_vec = '0;
    frame(); frame();
    chk_en = 1'b1;
    check("rst_score", 32'(score), 0);
    check("rst_playing", 32'(playing), 0);
    check("rst_game_over", 32'(game_over), 0);
    Reset = 1'b0;

    // Rise while idle is ignored
    hit_vec[0] = 1'b1; frame();
    check("idle_hit_count", 32'(hit_count), 0);
    check("idle_playing", 32'(playing), 0);

    // Start
    hit_vec = '0; keycode = 8'h2c; frame();
    check("start_playing", 32'(playing), 1);
    keycode = 8'h00;

    // Three single hits
    for (int i = 0; i < 3; i++) begin
      hit_vec[i] = 1'b1; frame();
    end
    check("simple_score", 32'(score), 3);
    check("simple_combo", 32'(combo), 3);
    check("simple_max", 32'(max_combo), 3);
    check("simple_hits", 32'(hit_count), 3);

    // Hit and miss in the same frame
    miss_vec[3] = 1'b1; hit_vec[4] = 1'b1; frame();
    check("break_combo", 32'(combo), 0);
    check("break_max", 32'(max_combo), 4);
    check("break_hits", 32'(hit_count), 4);
    check("break_miss", 32'(miss_count), 1);

    // Simultaneous hit+miss counts as a hit; re-rise ignored
    hit_vec[5] = 1'b1; miss_vec[5] = 1'b1; frame();
    check("both_hits", 32'(hit_count), 5);
    check("both_miss", 32'(miss_count), 1);
    hit_vec[5] = 1'b0; miss_vec[5] = 1'b0; frame();
    hit_vec[5] = 1'b1; miss_vec[5] = 1'b1; frame();
    check("rerise_hits", 32'(hit_count), 5);
    check("rerise_combo", 32'(combo), 1);

    // Finish the song one note per frame; score clamps at SM
    for (int i = 6; i < N; i++) begin
      hit_vec[i] = 1'b1; frame();
    end
    check("end_hits", 32'(hit_count), 31);
    check("end_score_clamp", 32'(score), 30);
    check("end_max", 32'(max_combo), 27);
    check("end_not_over_yet", 32'(game_over), 0);
    frame();
    check("game_over", 32'(game_over), 1);
    check("over_playing", 32'(playing), 0);

    // Back to idle, counters held
    keycode = 8'h01; hit_vec = '0; miss_vec = '0; frame();
    check("idle_game_over", 32'(game_over), 0);
    check("idle_held_hits", 32'(hit_count), 31);
    keycode = 8'h00; frame();
    check("idle_held_miss", 32'(miss_count), 1);

    // Restart clears
    keycode = 8'h2c; frame();
    keycode = 8'h00;
    check("restart_hits", 32'(hit_count), 0);
    check("restart_score", 32'(score), 0);
    check("restart_max", 32'(max_combo), 0);

    // Twelve consecutive single hits
    for (int i = 0; i < 12; i++) begin
      hit_vec[i] = 1'b1; frame();
    end
    check("twelve_score", 32'(score), 32'(exp12));
    check("twelve_combo", 32'(combo), 12);

    // Remaining twenty in one frame
    hit_vec = '1; frame();
    check("all_hits", 32'(hit_count), 32);
    check("all_combo", 32'(combo), 32);
    check("all_score_clamp", 32'(score), 30);
    check("all_max", 32'(max_combo), 32);
    frame();
    check("all_game_over", 32'(game_over), 1);

    // Third song: two hits then a double miss, then reset mid-song
    keycode = 8'h01; hit_vec = '0; frame();
    keycode = 8'h2c; frame();
    keycode = 8'h00;
    hit_vec[0] = 1'b1; frame();
    hit_vec[1] = 1'b1; frame();
    miss_vec[2] = 1'b1; miss_vec[3] = 1'b1; frame();
    check("dbl_miss", 32'(miss_count), 2);
    check("dbl_combo", 32'(combo), 0);
    check("dbl_max", 32'(max_combo), 2);
    Reset = 1'b1; frame();
    check("midrst_hits", 32'(hit_count), 0);
    check("midrst_playing", 32'(playing), 0);
    Reset = 1'b0; frame();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
